// File: rtl/mem_responder.sv
// Word-addressed memory responder: byte-masked writes, fixed-latency in-order reads, sticky range error.
// Optional stall injection on mem_ready_o via MEM_RESPONDER_STALL_EN; no response backpressure.
module mem_responder #(
    parameter int Xlen        = 32,
    parameter int MaskBits    = Xlen / 8,
    parameter int DepthWords  = 1024,
    parameter int Latency     = 1,
    parameter int StallPeriod = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [Xlen-1:0]     mem_addr_i,
    input  logic [Xlen-1:0]     mem_wdata_i,
    input  logic [MaskBits-1:0] mem_wmask_i,
    output logic [Xlen-1:0]     mem_rdata_o,
    output logic                mem_rvalid_o,
    output logic                err_o
);

    localparam int AW = (DepthWords > 1) ? $clog2(DepthWords) : 1;

    logic [Xlen-1:0]   r_mem [DepthWords];
    logic [Latency-1:0] r_pipe_vld;
    logic [Xlen-1:0]   r_pipe_dat [Latency];
    logic              r_err;

    logic [Xlen-3:0] w_idx;
    logic            w_in_range;
    logic            w_stall;
    logic            w_acc;
    logic            w_is_rd;
    logic [Xlen-1:0] w_rd_dat;
    logic            unused_bits;

    assign w_idx      = mem_addr_i[Xlen-1:2];
    assign w_in_range = (w_idx < (Xlen-2)'(DepthWords));

`ifdef MEM_RESPONDER_STALL_EN
    logic [7:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt == 8'(StallPeriod - 1)) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    assign w_stall = (r_stall_cnt == 8'(StallPeriod - 1));
`else
    assign w_stall = 1'b0;
`endif

    assign mem_ready_o = !rst_i && !w_stall;
    assign w_acc       = mem_valid_i && mem_ready_o;
    assign w_is_rd     = (mem_wmask_i == '0);
    assign w_rd_dat    = w_in_range ? r_mem[w_idx[AW-1:0]] : '0;
    assign unused_bits = ^{mem_addr_i[1:0], StallPeriod[0]};

    // Storage has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_acc && !w_is_rd && w_in_range) begin
            for (int i = 0; i < MaskBits; i++) begin
                if (mem_wmask_i[i]) begin
                    r_mem[w_idx[AW-1:0]][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Data is captured at acceptance and zeroed when the stage carries no read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < Latency; i++) begin
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_acc && w_is_rd;
            r_pipe_dat[0] <= (w_acc && w_is_rd) ? w_rd_dat : '0;
            for (int i = 1; i < Latency; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_acc && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign mem_rvalid_o = r_pipe_vld[Latency-1];
    assign mem_rdata_o  = r_pipe_vld[Latency-1] ? r_pipe_dat[Latency-1] : '0;
    assign err_o        = r_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter Xlen, default 32, data and address width in bits.
REQ-002 Parameter MaskBits, default Xlen/8, number of byte-enable bits.
REQ-003 Parameter DepthWords, default 1024, number of Xlen-bit words of storage.
REQ-004 Parameter Latency, default 1, range 1..4, cycles from request acceptance to read response.
REQ-005 Parameter StallPeriod, default 8, range 2..255, stall-injection period in cycles.
REQ-006 clk_i  input  1  single clock, all logic rising-edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 mem_valid_i  input  1  request valid from initiator.
REQ-009 mem_ready_o  output  1  responder can accept a request this cycle.
REQ-010 mem_addr_i  input  Xlen  byte address; bits [1:0] ignored (word addressing).
REQ-011 mem_wdata_i  input  Xlen  write data.
REQ-012 mem_wmask_i  input  MaskBits  byte enables; all-zero means read, nonzero means write.
REQ-013 mem_rdata_o  output  Xlen  read response data.
REQ-014 mem_rvalid_o  output  1  read response valid, one-cycle pulse per read.
REQ-015 err_o  output  1  sticky out-of-range access flag.

Function
REQ-016 Request accepted in any cycle with mem_valid_i && mem_ready_o; no other cycle alters storage or launches a response.
REQ-017 Word index = mem_addr_i[Xlen-1:2]; in range when index < DepthWords.
REQ-018 Accepted write, in range: byte lane i updated from mem_wdata_i[8i+7:8i] iff mem_wmask_i[i]; other lanes unchanged; no response generated.
REQ-019 Accepted read: mem_rvalid_o pulses exactly Latency cycles after acceptance cycle, mem_rdata_o holds the word during that cycle.
REQ-020 Read data sampled at acceptance; write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
REQ-021 Back-to-back reads, one per cycle, sustained; responses strictly in acceptance order; up to Latency reads in flight, held in a Latency-stage valid/data shift pipeline.
REQ-022 No response backpressure: initiator always consumes mem_rvalid_o; pipeline never stalls.
REQ-023 mem_rdata_o = 0 in cycles with mem_rvalid_o low.
REQ-024 Out-of-range read: response still issued at normal latency with data 0; err_o set.
REQ-025 Out-of-range write: storage unchanged; err_o set.
REQ-026 err_o remains 1 until rst_i; simultaneous in-range and error conditions impossible (one request per cycle).
REQ-027 Address wrap-around not performed; indices >= DepthWords are always out of range.

Reset
REQ-028 While rst_i high: mem_ready_o 0, mem_rvalid_o 0, mem_rdata_o 0, err_o 0, stall counter 0.
REQ-029 rst_i asserted mid-operation discards all in-flight reads; no mem_rvalid_o pulse for them after deassertion.
REQ-030 Storage array contents not cleared by reset.
REQ-031 mem_ready_o first high in the first rising-edge cycle after rst_i deasserts (subject to REQ-033).

Configuration
REQ-032 Macro MEM_RESPONDER_STALL_EN selects stall injection.
REQ-033 With MEM_RESPONDER_STALL_EN defined: free-running counter 0..StallPeriod-1 advancing every cycle out of reset; mem_ready_o low when counter == StallPeriod-1, high otherwise; in-flight responses unaffected.
REQ-034 Without MEM_RESPONDER_STALL_EN: no counter; mem_ready_o high in every cycle out of reset.

Verification
REQ-035 Write addr 0x10 data 0xDEADBEEF mask 0xF, then read 0x10 next cycle -> rvalid Latency cycles later, rdata 0xDEADBEEF.
REQ-036 Preload 0x11223344 at 0x20, write mask 0x2 data 0x0000AA00, read 0x20 -> rdata 0x1122AA44.
REQ-037 Latency=3, reads of 0x0,0x4,0x8 in consecutive cycles (contents 1,2,3) -> rvalid in three consecutive cycles starting 3 cycles after first accept, rdata 1,2,3.
REQ-038 DepthWords=1024, read 0x1000 -> rvalid with rdata 0, err_o 1 and held; write 0x1000 leaves word 0 unchanged.
REQ-039 Latency=2, read accepted, rst_i pulsed the next cycle -> no rvalid after reset; ready_o 0 during reset, err_o 0.
REQ-040 MEM_RESPONDER_STALL_EN, StallPeriod=4, valid_i held high -> ready_o low every 4th cycle, 3 accepts per 4 cycles, no request lost or duplicated.
